// File: rtl/x3q16_spi_mem_pkg.sv
// Shared constants, FSM encoding and SPI frame builder for the x3q16 serial-SRAM back-end.
package x3q16_mem_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
  localparam int         FRAME_BITS    = 40;
  localparam int         DATA_BITS     = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE,
    ST_GUARD
  } mem_state_e;

  // Command byte, 16-bit byte address (word address * 2), then data; reads shift zeros.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic                 is_write,
    input logic [14:0]          word_addr,
    input logic [DATA_BITS-1:0] data
  );
    build_frame = {is_write ? SPI_CMD_WRITE : SPI_CMD_READ,
                   word_addr, 1'b0,
                   is_write ? data : {DATA_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/x3q16_spi_mem_bit_engine.sv
// SPI mode-0 bit engine: SCLK divider, 40-bit MSB-first shifter and bit counter.
// start loads a frame; done is high on the cycle the last SCLK high half ends.
module spi_bit_engine
  import x3q16_mem_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic [DATA_BITS-1:0]  rx_word,
  output logic                  done
);

  logic                  active;
  logic [FRAME_BITS-1:0] shreg;
  logic [7:0]            div_cnt;
  logic [5:0]            bit_cnt;
  logic                  half_end;

  assign half_end = (div_cnt == 8'(CLK_DIV - 1));
  assign done     = active && sclk && half_end && (bit_cnt == 6'(FRAME_BITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active  <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      shreg   <= '0;
      div_cnt <= 8'd0;
      bit_cnt <= 6'd0;
      rx_word <= '0;
    end else if (start) begin
      active  <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= frame[FRAME_BITS-1];
      shreg   <= {frame[FRAME_BITS-2:0], 1'b0};
      div_cnt <= 8'd0;
      bit_cnt <= 6'd0;
    end else if (active) begin
      if (!half_end) begin
        div_cnt <= div_cnt + 8'd1;
      end else begin
        div_cnt <= 8'd0;
        if (!sclk) begin
          // Rising edge: MISO has been stable for the whole low half.
          sclk    <= 1'b1;
          rx_word <= {rx_word[DATA_BITS-2:0], miso};
        end else if (done) begin
          active <= 1'b0;
          sclk   <= 1'b0;
          mosi   <= 1'b0;
        end else begin
          sclk    <= 1'b0;
          mosi    <= shreg[FRAME_BITS-1];
          shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
          bit_cnt <= bit_cnt + 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/x3q16_spi_mem.sv
// x3q16 memory back-end: core request pulses -> 23LC512-class SPI SRAM transactions.
// Optional memory_critical flag is built only when X3Q16_SPI_MEM_CRIT_EN is defined.
module x3q16_spi_mem
  import x3q16_mem_pkg::*;
#(
  parameter int          CLK_DIV   = 2,
  parameter int          GUARD     = 2,
  parameter logic [15:0] CRIT_ADDR = 16'hFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        request,
  input  logic        request_type,
  input  logic [15:0] request_address,
  input  logic [15:0] data_out,
  output logic [15:0] memory_in,
  output logic        memory_ready,
  output logic        write_complete,
  output logic        memory_critical,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  mem_state_e            state;
  logic                  buf_full;
  logic                  buf_type;
  logic [15:0]           buf_addr;
  logic [15:0]           buf_data;
  logic                  cur_type;
  logic [7:0]            guard_cnt;
  logic                  sel_type;
  logic [15:0]           sel_addr;
  logic [15:0]           sel_data;
  logic                  eng_start;
  logic                  eng_done;
  logic [DATA_BITS-1:0]  rx_word;
  logic [FRAME_BITS-1:0] frame;

  // A buffered request always wins over a same-cycle one, which is then dropped.
  always_comb begin
    sel_type  = buf_full ? buf_type : request_type;
    sel_addr  = buf_full ? buf_addr : request_address;
    sel_data  = buf_full ? buf_data : data_out;
    eng_start = (state == ST_IDLE) && (buf_full || request);
    frame     = build_frame(sel_type, sel_addr[14:0], sel_data);
  end

  spi_bit_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk     (clk),
    .reset   (reset),
    .start   (eng_start),
    .frame   (frame),
    .miso    (spi_miso),
    .sclk    (spi_sclk),
    .mosi    (spi_mosi),
    .rx_word (rx_word),
    .done    (eng_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      buf_full       <= 1'b0;
      buf_type       <= 1'b0;
      buf_addr       <= 16'h0;
      buf_data       <= 16'h0;
      cur_type       <= 1'b0;
      guard_cnt      <= 8'd0;
      memory_in      <= 16'h0;
      memory_ready   <= 1'b0;
      write_complete <= 1'b0;
      spi_cs_n       <= 1'b1;
    end else begin
      memory_ready   <= 1'b0;
      write_complete <= 1'b0;
      if (request && !buf_full && (state != ST_IDLE)) begin
        buf_full <= 1'b1;
        buf_type <= request_type;
        buf_addr <= request_address;
        buf_data <= data_out;
      end
      case (state)
        ST_IDLE: begin
          if (eng_start) begin
            spi_cs_n <= 1'b0;
            cur_type <= sel_type;
            buf_full <= 1'b0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (eng_done) begin
            spi_cs_n <= 1'b1;
            state    <= ST_DONE;
            if (cur_type) begin
              write_complete <= 1'b1;
            end else begin
              memory_ready <= 1'b1;
              memory_in    <= rx_word;
            end
          end
        end
        ST_DONE: begin
          guard_cnt <= 8'(GUARD - 1);
          state     <= ST_GUARD;
        end
        ST_GUARD: begin
          if (guard_cnt == 8'd0) state <= ST_IDLE;
          else                   guard_cnt <= guard_cnt - 8'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef X3Q16_SPI_MEM_CRIT_EN
  logic [15:0] cur_addr;
  logic        crit_flag;

  // Sticky until reset; bit 15 takes part in the compare even though the bus drops it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_addr  <= 16'h0;
      crit_flag <= 1'b0;
    end else begin
      if (eng_start) cur_addr <= sel_addr;
      if (eng_done && cur_type && (cur_addr >= CRIT_ADDR)) crit_flag <= 1'b1;
    end
  end

  assign memory_critical = crit_flag;
`else
  logic unused_crit;
  assign unused_crit     = ^{CRIT_ADDR, sel_addr[15]};
  assign memory_critical = 1'b0;
`endif

endmodule
